jk_bank_arbiter: RTL and testbench



---
 rtl/jk_bank_pkg.sv | 22 ++
 rtl/jk_cell.sv | 33 +++
 rtl/jk_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
// Shared constants for the JK bank arbiter.
//   - JK opcodes, {J,K} as driven onto a selected cell
//   - FSM state encoding for the arbiter
//   - requester id encoding carried on done_id
package jk_bank_pkg;

    // {J,K} opcodes
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    // Arbiter FSM states
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] APPLY   = 2'b01;
    localparam logic [1:0] RESP    = 2'b10;

    // Requester ids
    localparam logic       ID_A    = 1'b0;
    localparam logic       ID_B    = 1'b1;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with synchronous active-high reset.
// Ports:
//   clk_i - rising-edge clock
//   rst_i - synchronous active-high reset, wins over J/K
//   j_i   - J input (set)
//   k_i   - K input (clear); J=K=1 toggles, J=K=0 holds
//   q_o   - current cell state
module jk_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else begin
            unique case ({j_i, k_i})
                2'b00:   q_q <= q_q;
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                default: q_q <= ~q_q;
            endcase
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of WIDTH JK cells between requesters A and B.
// A command is accepted in IDLE, driven onto the cells for exactly one cycle in
// APPLY, and acknowledged with a one-cycle done pulse in RESP.
// Optional feature: define JK_BANK_STATS_EN to add 16-bit per-requester accept
// counters a_count / b_count.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   a_valid/a_op/a_mask  - requester A command (op: 00 hold, 01 clr, 10 set, 11 tog)
//   a_ready              - A accepted this cycle
//   b_valid/b_op/b_mask  - requester B command
//   b_ready              - B accepted this cycle
//   done, done_id        - completion pulse and winner id (0 = A, 1 = B)
//   bank_q               - Q of all cells
//   busy                 - FSM not in IDLE
//   a_count, b_count     - accept counters (JK_BANK_STATS_EN only)
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_mask,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_mask,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] bank_q,
    output logic             busy
`ifdef JK_BANK_STATS_EN
   ,output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             id_q, id_d;
    logic             last_q, last_d;  // last granted requester
    logic             winner;
    logic             accept;
    logic             apply;
    logic [WIDTH-1:0] cell_j, cell_k;

    // Sole valid requester wins; on contention the one not granted last wins.
    always_comb begin
        if (a_valid && b_valid) begin
            winner = ~last_q;
        end else if (b_valid) begin
            winner = ID_B;
        end else begin
            winner = ID_A;
        end
    end

    assign a_ready = (state_q == IDLE) && a_valid && (winner == ID_A);
    assign b_ready = (state_q == IDLE) && b_valid && (winner == ID_B);
    assign accept  = a_ready || b_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mask_d  = mask_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = (winner == ID_B) ? b_op : a_op;
                    mask_d  = (winner == ID_B) ? b_mask : a_mask;
                    id_d    = winner;
                    last_d  = winner;
                    state_d = APPLY;
                end
            end
            APPLY:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            mask_q  <= '0;
            id_q    <= ID_A;
            last_q  <= ID_B;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Cells see J=K=0 except during the single APPLY cycle.
    assign apply  = (state_q == APPLY);
    assign cell_j = (apply && (op_q == OP_SET || op_q == OP_TOG)) ? mask_q : '0;
    assign cell_k = (apply && (op_q == OP_CLR || op_q == OP_TOG)) ? mask_q : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk_i (clk),
            .rst_i (rst),
            .j_i   (cell_j[i]),
            .k_i   (cell_k[i]),
            .q_o   (bank_q[i])
        );
    end

    assign done    = (state_q == RESP);
    assign done_id = done ? id_q : ID_A;
    assign busy    = (state_q != IDLE);

`ifdef JK_BANK_STATS_EN
    logic [15:0] a_count_q, b_count_q;

    // Natural 16-bit wrap from 0xFFFF to 0x0000.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            if (a_ready) a_count_q <= a_count_q + 16'd1;
            if (b_ready) b_count_q <= b_count_q + 16'd1;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;

    localparam int W = 8;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] mask;
    } cmd_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [1:0]   a_op, b_op;
    logic [W-1:0] a_mask, b_mask;
    logic         done, done_id, busy;
    logic [W-1:0] bank_q;
`ifdef JK_BANK_STATS_EN
    logic [15:0]  a_count, b_count;
`endif

    jk_bank_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_op    (a_op),
        .a_mask  (a_mask),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_op    (b_op),
        .b_mask  (b_mask),
        .done    (done),
        .done_id (done_id),
        .bank_q  (bank_q),
        .busy    (busy)
`ifdef JK_BANK_STATS_EN
       ,.a_count (a_count),
        .b_count (b_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester command queues (heads are presented on the ports)
    cmd_t qa[$];
    cmd_t qb[$];

    // Transaction-level reference model
    logic [W-1:0] m_bank;
    int           m_age;      // cycles since accept of the in-flight command, 0 = none
    logic         m_id;
    cmd_t         m_cmd;
    logic         m_last;     // last granted: 0 = A, 1 = B
    int           m_acnt, m_bcnt;
    int           cyc;
    int           grants[$];
    int           grant_cyc[$];
    int           dones[$];
    int           done_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input logic av, input logic bv, input logic last);
        if (av && bv) return (last == 1'b1) ? 1'b0 : 1'b1;
        if (av) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] apply_cmd(input logic [W-1:0] bank, input cmd_t c);
        case (c.op)
            2'b01:   return bank & ~c.mask;
            2'b10:   return bank | c.mask;
            2'b11:   return bank ^ c.mask;
            default: return bank;
        endcase
    endfunction

    task automatic model_reset();
        m_bank = '0;
        m_age  = 0;
        m_id   = 1'b0;
        m_last = 1'b1;
        m_acnt = 0;
        m_bcnt = 0;
    endtask

    // One clock cycle: present queue heads, check at negedge, advance model at posedge.
    task automatic cycle();
        logic win, exp_ar, exp_br, acc_a, acc_b;
        a_valid = (qa.size() > 0);
        a_op    = a_valid ? qa[0].op : 2'b00;
        a_mask  = a_valid ? qa[0].mask : '0;
        b_valid = (qb.size() > 0);
        b_op    = b_valid ? qb[0].op : 2'b00;
        b_mask  = b_valid ? qb[0].mask : '0;
        @(negedge clk);
        win    = pick(a_valid, b_valid, m_last);
        exp_ar = (m_age == 0) && a_valid && !win;
        exp_br = (m_age == 0) && b_valid && win;
        chk("a_ready", a_ready, exp_ar);
        chk("b_ready", b_ready, exp_br);
        chk("busy", busy, m_age != 0);
        chk("done", done, m_age == 2);
        chk("done_id", done_id, (m_age == 2) ? m_id : 1'b0);
        chk("bank_q", bank_q, m_bank);
`ifdef JK_BANK_STATS_EN
        chk("a_count", a_count, m_acnt & 32'hFFFF);
        chk("b_count", b_count, m_bcnt & 32'hFFFF);
`endif
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (m_age == 2) begin
                dones.push_back(int'(m_id));
                done_cyc.push_back(cyc - 1);
                m_age = 0;
            end else if (m_age == 1) begin
                m_bank = apply_cmd(m_bank, m_cmd);
                m_age  = 2;
            end else if (exp_ar || exp_br) begin
                m_id   = exp_br;
                m_cmd  = exp_br ? qb[0] : qa[0];
                m_last = exp_br;
                m_age  = 1;
                if (exp_br) m_bcnt++; else m_acnt++;
                grants.push_back(int'(exp_br));
                grant_cyc.push_back(cyc - 1);
            end
        end
        // Requesters drop a command once they have seen their ready.
        if (acc_a && qa.size() > 0) void'(qa.pop_front());
        if (acc_b && qb.size() > 0) void'(qb.pop_front());
        #1;
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || m_age != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $error("FAIL timeout got=%0d exp=<%0d", n, budget);
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic do_reset();
        qa.delete();
        qb.delete();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grants.delete();
        grant_cyc.delete();
        dones.delete();
        done_cyc.delete();
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_op = 2'b00; a_mask = '0;
        b_valid = 1'b0; b_op = 2'b00; b_mask = '0;
        cyc = 0;
        model_reset();
        #1;
        do_reset();
        cycle();

        // A set 0x0F: accept at T, done at T+2
        qa.push_back('{op: 2'b10, mask: 8'h0F});
        run_idle(20);
        chk("set_bank", bank_q, 8'h0F);
        chk("set_done_id", (dones.size() == 1) ? dones[0] : -1, 0);
        chk("set_latency", (done_cyc.size() == 1 && grant_cyc.size() == 1) ?
            done_cyc[0] - grant_cyc[0] : -1, 2);

        // B toggle all, twice
        qb.push_back('{op: 2'b11, mask: 8'hFF});
        run_idle(20);
        chk("tog1_bank", bank_q, 8'hF0);
        chk("tog1_id", dones[$], 1);
        qb.push_back('{op: 2'b11, mask: 8'hFF});
        run_idle(20);
        chk("tog2_bank", bank_q, 8'h0F);

        // Contention right after reset: A first, B three cycles later
        do_reset();
        qa.push_back('{op: 2'b10, mask: 8'h01});
        qb.push_back('{op: 2'b10, mask: 8'h02});
        run_idle(30);
        chk("cont_g0", (grants.size() == 2) ? grants[0] : -1, 0);
        chk("cont_g1", (grants.size() == 2) ? grants[1] : -1, 1);
        chk("cont_gap", (grant_cyc.size() == 2) ? grant_cyc[1] - grant_cyc[0] : -1, 3);
        chk("cont_done_order", (dones.size() == 2) ? {dones[0][0], dones[1][0]} : 32'hF, 2'b01);
        chk("cont_bank", bank_q, 8'h03);

        // Both held valid for six transactions: strict alternation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            qa.push_back('{op: 2'b11, mask: 8'h0F});
            qb.push_back('{op: 2'b11, mask: 8'hF0});
        end
        run_idle(60);
        chk("alt_count", grants.size(), 6);
        for (int i = 0; i < grants.size(); i++) chk("alt_grant", grants[i], i % 2);
        chk("alt_bank", bank_q, 8'hFF);

        // Empty mask and hold op are still full transactions
        do_reset();
        qa.push_back('{op: 2'b10, mask: 8'hAA});
        run_idle(20);
        dones.delete();
        qa.push_back('{op: 2'b01, mask: 8'h00});
        run_idle(20);
        chk("nomask_done", dones.size(), 1);
        chk("nomask_bank", bank_q, 8'hAA);
        qa.push_back('{op: 2'b00, mask: 8'hFF});
        run_idle(20);
        chk("hold_done", dones.size(), 2);
        chk("hold_bank", bank_q, 8'hAA);

        // Reset during APPLY discards the transaction
        qa.push_back('{op: 2'b10, mask: 8'hFF});
        for (int n = 0; n < 10 && qa.size() > 0; n++) cycle();
        chk("rstmid_accepted", qa.size(), 0);
        dones.delete();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("rstmid_no_done", dones.size(), 0);
        chk("rstmid_bank", bank_q, 8'h00);
        chk("rstmid_busy", busy, 1'b0);
        grants.delete();
        qa.push_back('{op: 2'b10, mask: 8'h10});
        qb.push_back('{op: 2'b10, mask: 8'h20});
        run_idle(30);
        chk("rstmid_first", (grants.size() > 0) ? grants[0] : -1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (qa.size() == 0 && $urandom_range(0, 2) == 0)
                qa.push_back('{op: 2'($urandom), mask: W'($urandom)});
            if (qb.size() == 0 && $urandom_range(0, 2) == 0)
                qb.push_back('{op: 2'($urandom), mask: W'($urandom)});
            cycle();
        end
        run_idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
